// File: rtl/olive_servo_gen.sv
// olive_servo_gen: multi-channel servo output generator with per-channel
// PWM or first-order delta-sigma mode, programmable period and prescaler,
// and double-buffered width/mode registers that swap only at a period wrap.
//
// Bus handshake: avs_write is a single-cycle strobe; the addressed register
// updates at the next clock edge. avs_read is a single-cycle strobe and
// avs_readdata is valid exactly one cycle later. A read and a write to the
// same address in one cycle return the pre-write value. No wait states.
module olive_servo_gen #(
    parameter int CHANNELS       = 8,
    parameter int WIDTH          = 16,
    parameter int PRESC_WIDTH    = 16,
    parameter int DEFAULT_PERIOD = 19999,
    parameter int DEFAULT_PRESC  = 99
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [4:0]          avs_address,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    output logic [CHANNELS-1:0] servo_pwm,
    output logic [CHANNELS-1:0] servo_dsm,
    output logic                period_strobe
);

    // Live (bus-visible) registers
    logic                   ctrl_en;
    logic [WIDTH-1:0]       period_reg;
    logic [PRESC_WIDTH-1:0] presc_reg;
    logic [CHANNELS-1:0]    mode_reg;
    logic [WIDTH-1:0]       width_reg [CHANNELS];

    // Timebase
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [WIDTH-1:0]       period_cnt;
    logic                   tick;
    logic                   wrap;

    // Per-channel working copies, swapped at the wrap
    logic [WIDTH-1:0]       shadow_width [CHANNELS];
    logic [CHANNELS-1:0]    shadow_mode;
    logic [WIDTH-1:0]       acc [CHANNELS];
    logic [WIDTH:0]         dsm_sum [CHANNELS];

    logic [31:0]            rd_mux;
    logic                   unused_wdata;

    // Bits of the write bus above the register widths are intentionally dropped
    assign unused_wdata = ^avs_writedata;

    assign tick = ctrl_en && (presc_cnt == presc_reg);
    assign wrap = tick && (period_cnt == period_reg);

    // Register file writes; bits beyond each register's width are discarded
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en    <= 1'b0;
            period_reg <= WIDTH'(DEFAULT_PERIOD);
            presc_reg  <= PRESC_WIDTH'(DEFAULT_PRESC);
            mode_reg   <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                width_reg[n] <= '0;
            end
        end else if (avs_write) begin
            case (avs_address)
                5'd0:    ctrl_en    <= avs_writedata[0];
                5'd1:    period_reg <= avs_writedata[WIDTH-1:0];
                5'd2:    presc_reg  <= avs_writedata[PRESC_WIDTH-1:0];
                5'd3:    mode_reg   <= avs_writedata[CHANNELS-1:0];
                default: begin
                end
            endcase
            for (int n = 0; n < CHANNELS; n++) begin
                if (avs_address == 5'(4 + n)) begin
                    width_reg[n] <= avs_writedata[WIDTH-1:0];
                end
            end
        end
    end

    // Read decode; unmapped addresses and unused high bits read as zero
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            5'd0: rd_mux[0]               = ctrl_en;
            5'd1: rd_mux[WIDTH-1:0]       = period_reg;
            5'd2: rd_mux[PRESC_WIDTH-1:0] = presc_reg;
            5'd3: rd_mux[CHANNELS-1:0]    = mode_reg;
            default: begin
                for (int n = 0; n < CHANNELS; n++) begin
                    if (avs_address == 5'(4 + n)) begin
                        rd_mux[WIDTH-1:0] = width_reg[n];
                    end
                end
            end
        endcase
    end

    // Registered read data, one cycle after the read strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else begin
            avs_readdata <= avs_read ? rd_mux : '0;
        end
    end

    // Prescaler and period counter; both held at zero while disabled.
    // A PERIOD below the current count lets the counter run through all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt     <= '0;
            period_cnt    <= '0;
            period_strobe <= 1'b0;
        end else begin
            period_strobe <= wrap;
            if (!ctrl_en) begin
                presc_cnt  <= '0;
                period_cnt <= '0;
            end else begin
                presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
                if (wrap) begin
                    period_cnt <= '0;
                end else if (tick) begin
                    period_cnt <= period_cnt + 1'b1;
                end
            end
        end
    end

    // Shadow registers follow the live ones while disabled, else load at wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_mode <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                shadow_width[n] <= '0;
            end
        end else if (!ctrl_en || wrap) begin
            shadow_mode <= mode_reg;
            for (int n = 0; n < CHANNELS; n++) begin
                shadow_width[n] <= width_reg[n];
            end
        end
    end

    // Delta-sigma adder: carry out of acc + width is the DSM bit
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            dsm_sum[n] = {1'b0, acc[n]} + {1'b0, shadow_width[n]};
        end
    end

    // Channel outputs. The old mode's output keeps running through the wrap
    // cycle and both outputs switch together on the cycle after it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            servo_pwm <= '0;
            servo_dsm <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                acc[n] <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (!ctrl_en) begin
                    acc[n]       <= '0;
                    servo_pwm[n] <= 1'b0;
                    servo_dsm[n] <= 1'b0;
                end else begin
                    servo_pwm[n] <= !shadow_mode[n] && (period_cnt < shadow_width[n]);

                    if (!shadow_mode[n]) begin
                        servo_dsm[n] <= 1'b0;
                    end else if (tick) begin
                        servo_dsm[n] <= dsm_sum[n][WIDTH];
                    end

                    if (wrap && (mode_reg[n] != shadow_mode[n])) begin
                        acc[n] <= '0;
                    end else if (shadow_mode[n] && tick) begin
                        acc[n] <= dsm_sum[n][WIDTH-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_olive_servo_gen.sv
// Self-checking bench for olive_servo_gen (default parameters: 8 channels,
// 16-bit width). Drivers push expected values into queues; a negedge monitor
// pops and compares whenever read data or an output sample is presented.
module tb_olive_servo_gen;

    logic        clk;
    logic        reset_n;
    logic [4:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [7:0]  servo_pwm;
    logic [7:0]  servo_dsm;
    logic        period_strobe;

    olive_servo_gen dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .servo_pwm     (servo_pwm),
        .servo_dsm     (servo_dsm),
        .period_strobe (period_strobe)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] rd_exp_q[$];
    logic [4:0]  rd_addr_q[$];
    logic [16:0] out_exp_q[$];
    logic        rd_valid;
    logic        obs_valid;
    logic        end_chk;
    int          n_cmp;
    int          n_fail;

    // Read data is presented the cycle after a read strobe
    always @(posedge clk) rd_valid <= avs_read;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e32;
        logic [4:0]  a;
        logic [16:0] e17;
        logic [16:0] act;
        if (rd_valid) begin
            n_cmp++;
            if (rd_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL readback: got unexpected data %h, required no read", avs_readdata);
            end else begin
                e32 = rd_exp_q.pop_front();
                a   = rd_addr_q.pop_front();
                if (avs_readdata !== e32) begin
                    n_fail++;
                    $display("FAIL readback addr %0d: got %h, required %h", a, avs_readdata, e32);
                end
            end
        end
        if (obs_valid) begin
            act = {period_strobe, servo_dsm, servo_pwm};
            n_cmp++;
            if (out_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL outputs: got sample %h, required none", act);
            end else begin
                e17 = out_exp_q.pop_front();
                if (act !== e17) begin
                    n_fail++;
                    $display("FAIL outputs at %0t: got strobe/dsm/pwm %b/%b/%b, required %b/%b/%b",
                             $time, act[16], act[15:8], act[7:0], e17[16], e17[15:8], e17[7:0]);
                end
            end
        end
        if (end_chk) begin
            n_cmp++;
            if (rd_exp_q.size() != 0 || out_exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d/%0d expectations left, required 0/0",
                         rd_exp_q.size(), out_exp_q.size());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        cyc();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e);
        rd_exp_q.push_back(e);
        rd_addr_q.push_back(a);
        avs_address = a;
        avs_read    = 1'b1;
        cyc();
        avs_read    = 1'b0;
    endtask

    // Expect {strobe, dsm, pwm} during the cycle that follows
    task automatic step(input logic [16:0] e);
        out_exp_q.push_back(e);
        obs_valid = 1'b1;
        cyc();
        obs_valid = 1'b0;
    endtask

    task automatic set_wr(input logic [4:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] p;
    logic [7:0] d;
    logic       s;
    logic       en_o;
    int         w0;

    initial begin
        reset_n       = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        obs_valid     = 1'b0;
        end_chk       = 1'b0;
        n_cmp         = 0;
        n_fail        = 0;
        repeat (3) cyc();
        reset_n = 1'b1;

        // Reset state and register map
        step(17'h0);
        rd(5'd0, 32'd0);
        rd(5'd1, 32'd19999);
        rd(5'd2, 32'd99);
        rd(5'd3, 32'd0);
        rd(5'd4, 32'd0);
        rd(5'd12, 32'd0);
        rd(5'd31, 32'd0);
        wr(5'd1, 32'hFFFF_0005);
        rd(5'd1, 32'd5);
        wr(5'd3, 32'hFFFF_FF81);
        rd(5'd3, 32'h81);
        wr(5'd3, 32'd0);
        // Read in the same cycle as a write returns the old value
        rd_exp_q.push_back(32'd99);
        rd_addr_q.push_back(5'd2);
        avs_address   = 5'd2;
        avs_writedata = 32'd0;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        cyc();
        avs_write     = 1'b0;
        avs_read      = 1'b0;
        rd(5'd2, 32'd0);

        // PERIOD=9, PRESCALE=0; W0=3, W1=0, W2=10 (> PERIOD), W3=5
        wr(5'd1, 32'd9);
        wr(5'd4, 32'd3);
        wr(5'd5, 32'd0);
        wr(5'd6, 32'd10);
        wr(5'd7, 32'd5);
        wr(5'd0, 32'd1);

        // k counts cycles after the enabling edge. Mid-period W0=7 at k=32,
        // W3=0x4000 at k=50, MODE=0x08 at k=51 (both swap at the k=60 wrap),
        // EN cleared at k=83 (outputs still live for k=84).
        for (int k = 0; k < 90; k++) begin
            if (k == 32) set_wr(5'd4, 32'd7);
            if (k == 50) set_wr(5'd7, 32'h4000);
            if (k == 51) set_wr(5'd3, 32'h08);
            if (k == 83) set_wr(5'd0, 32'd0);
            en_o = (k >= 1) && (k <= 84);
            w0   = (k >= 41) ? 7 : 3;
            p    = '0;
            d    = '0;
            p[0] = en_o && (k % 10 >= 1) && (k % 10 <= w0);
            p[2] = en_o;
            p[3] = en_o && (k <= 60) && (k % 10 >= 1) && (k % 10 <= 5);
            d[3] = en_o && (k >= 61) && ((k - 60) % 4 == 0);
            s    = en_o && (k >= 10) && (k % 10 == 0);
            step({s, d, p});
            avs_write = 1'b0;
        end

        // Re-enable: counting restarts from zero with current W0=7 and ch3 in DSM
        wr(5'd0, 32'd1);
        for (int j = 0; j < 25; j++) begin
            p    = '0;
            d    = '0;
            p[0] = (j >= 1) && (j % 10 >= 1) && (j % 10 <= 7);
            p[2] = (j >= 1);
            d[3] = (j >= 1) && (j % 4 == 0);
            s    = (j >= 10) && (j % 10 == 0);
            step({s, d, p});
        end

        // Reset mid-pulse (ch0 and ch2 high): outputs clear before the next edge
        reset_n = 1'b0;
        step(17'h0);
        step(17'h0);
        reset_n = 1'b1;
        step(17'h0);
        rd(5'd0, 32'd0);
        rd(5'd1, 32'd19999);
        rd(5'd2, 32'd99);
        rd(5'd3, 32'd0);
        rd(5'd4, 32'd0);
        cyc();

        end_chk = 1'b1;
        @(negedge clk);
        #1;
        end_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
